// File: rtl/mux_4to1_rr.sv
// Four-input valid/ready merger with round-robin arbitration and a registered,
// source-tagged output stage (dout/sel) suited to driving a 1:4 demultiplexer.
module mux_4to1_rr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             valid2,
  input  logic             valid3,
  output logic             ready0,
  output logic             ready1,
  output logic             ready2,
  output logic             ready3,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       sel,
  output logic             dout_valid,
  input  logic             dout_ready
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             vld_q, vld_d;

  logic [WIDTH-1:0] din_arr [4];
  logic [3:0]       valid_vec;
  logic [3:0]       ready_vec;
  logic [7:0]       valid_dbl;
  logic [3:0]       valid_rot;
  logic [1:0]       offset;
  logic [1:0]       grant;
  logic             load_en;
  logic             any_valid;

  assign din_arr[0] = din0;
  assign din_arr[1] = din1;
  assign din_arr[2] = din2;
  assign din_arr[3] = din3;
  assign valid_vec  = {valid3, valid2, valid1, valid0};

  assign load_en   = !vld_q || dout_ready;
  assign any_valid = |valid_vec;

  // Rotate the requests so bit 0 is the channel at ptr; the lowest set bit
  // is then the round-robin winner, offset from ptr.
  assign valid_dbl = {valid_vec, valid_vec};
  assign valid_rot = valid_dbl[{1'b0, ptr_q} +: 4];

  always_comb begin
    offset = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (valid_rot[i]) offset = 2'(i);
    end
  end

  assign grant = ptr_q + offset;

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    dout_d    = dout_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    vld_d     = vld_q;
    ready_vec = 4'b0000;
    if (load_en) begin
      if (any_valid) begin
        ready_vec[grant] = 1'b1;
        dout_d           = din_arr[grant];
        sel_d            = grant;
        vld_d            = 1'b1;
        ptr_d            = grant + 2'd1;
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      sel_q  <= 2'd0;
      ptr_q  <= 2'd0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      sel_q  <= sel_d;
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
    end
  end

  // Readies are combinational, so they are gated by reset directly.
  assign ready0 = ready_vec[0] && !rst;
  assign ready1 = ready_vec[1] && !rst;
  assign ready2 = ready_vec[2] && !rst;
  assign ready3 = ready_vec[3] && !rst;

  assign dout       = dout_q;
  assign sel        = sel_q;
  assign dout_valid = vld_q;

endmodule
